// File: rtl/ntt_bitrev_buffer.sv
// ----------------------------------------------------------------------------
// ntt_bitrev_buffer
//
// Ping-pong reorder buffer behind the NTT core. The core streams each frame of
// N coefficients in bit-reversed index order and cannot be stalled. This block
// writes each coefficient to its natural position in one of two banks. It then
// re-emits full banks in natural index order over a valid/ready interface.
// While one bank drains, the other bank fills.
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : coefficient present on in_data (no ready is returned)
//   in_data    : coefficient from the NTT core, bit-reversed order
//   out_valid  : out_data holds a natural-order coefficient
//   out_ready  : consumer accepts; transfer on out_valid & out_ready
//   out_data   : coefficient at natural index rd_cnt of the draining bank
//   out_last   : marks the final coefficient (index N-1) of a frame
//   overflow   : sticky flag, set when an input coefficient is dropped
// ----------------------------------------------------------------------------
module ntt_bitrev_buffer #(
   parameter int unsigned N    = 256,
   parameter int unsigned LOGN = 8,
   parameter int unsigned W    = 23
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         out_last,
   output logic         overflow
);

   typedef enum logic [1:0] {
      BANK_EMPTY   = 2'd0,
      BANK_FILLING = 2'd1,
      BANK_FULL    = 2'd2
   } bank_state_e;

   localparam logic [LOGN-1:0] CNT_LAST = LOGN'(N - 1);

   function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] idx);
      logic [LOGN-1:0] r;
      for (int b = 0; b < int'(LOGN); b++) begin
         r[b] = idx[int'(LOGN) - 1 - b];
      end
      return r;
   endfunction

   bank_state_e     bank_q [2];
   bank_state_e     bank_d [2];
   logic            wr_bank_q, wr_bank_d;
   logic [LOGN-1:0] wr_cnt_q,  wr_cnt_d;
   logic            rd_bank_q, rd_bank_d;
   logic [LOGN-1:0] rd_cnt_q,  rd_cnt_d;
   logic            overflow_q, overflow_d;

   logic [W-1:0]    mem_q [2][N];

   logic            rd_xfer;
   logic            rd_free;
   logic            wr_accept;

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      bank_d[0]  = bank_q[0];
      bank_d[1]  = bank_q[1];
      wr_bank_d  = wr_bank_q;
      wr_cnt_d   = wr_cnt_q;
      rd_bank_d  = rd_bank_q;
      rd_cnt_d   = rd_cnt_q;
      overflow_d = overflow_q;

      rd_xfer = (bank_q[rd_bank_q] == BANK_FULL) && out_ready;
      rd_free = rd_xfer && (rd_cnt_q == CNT_LAST);

      // A FULL write bank is still writable on the cycle its last word leaves.
      wr_accept = in_valid &&
                  ((bank_q[wr_bank_q] != BANK_FULL) ||
                   (rd_free && (rd_bank_q == wr_bank_q)));

      if (rd_xfer) begin
         rd_cnt_d = rd_cnt_q + 1'b1;
         if (rd_free) begin
            bank_d[rd_bank_q] = BANK_EMPTY;
            rd_bank_d         = ~rd_bank_q;
         end
      end

      // Evaluated after the read update so that on a freeing cycle the
      // released bank goes straight back to FILLING.
      if (wr_accept) begin
         wr_cnt_d = wr_cnt_q + 1'b1;
         if (wr_cnt_q == CNT_LAST) begin
            bank_d[wr_bank_q] = BANK_FULL;
            wr_bank_d         = ~wr_bank_q;
         end else begin
            bank_d[wr_bank_q] = BANK_FILLING;
         end
      end else if (in_valid) begin
         overflow_d = 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Control state
   // ------------------------------------------------------------------------
   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_q[0]  <= BANK_EMPTY;
         bank_q[1]  <= BANK_EMPTY;
         wr_bank_q  <= 1'b0;
         wr_cnt_q   <= '0;
         rd_bank_q  <= 1'b0;
         rd_cnt_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         bank_q[0]  <= bank_d[0];
         bank_q[1]  <= bank_d[1];
         wr_bank_q  <= wr_bank_d;
         wr_cnt_q   <= wr_cnt_d;
         rd_bank_q  <= rd_bank_d;
         rd_cnt_q   <= rd_cnt_d;
         overflow_q <= overflow_d;
      end
   end

   // ------------------------------------------------------------------------
   // Coefficient storage: the write address is bit-reversed, so the read side
   // simply walks natural indices.
   // ------------------------------------------------------------------------
   // NOTE: storage has no reset; bank state alone says whether contents are valid.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem_q[wr_bank_q][bitrev(wr_cnt_q)] <= in_data;
      end
   end

   // Outputs depend only on registered state and storage.
   assign out_valid = (bank_q[rd_bank_q] == BANK_FULL);
   assign out_data  = mem_q[rd_bank_q][rd_cnt_q];
   assign out_last  = out_valid && (rd_cnt_q == CNT_LAST);
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_ntt_bitrev_buffer.sv
// ----------------------------------------------------------------------------
// tb_ntt_bitrev_buffer
//
// Self-checking bench for ntt_bitrev_buffer. Stimulus tasks push the expected
// natural-order coefficients of each frame to a queue. A monitor pops one entry
// per output transfer and compares it. The monitor also checks that out_data
// and out_valid hold while the consumer stalls.
// ----------------------------------------------------------------------------
module tb_ntt_bitrev_buffer;

   localparam int N = 256;
   localparam int W = 23;

   typedef struct {
      logic [W-1:0] data;
      logic         last;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         out_last;
   logic         overflow;

   exp_t         exp_q[$];
   int           tests;
   int           fails;
   int           xfer_cnt;
   bit           stall_q;
   logic [W-1:0] held_data;

   ntt_bitrev_buffer #(.N(N), .LOGN(8), .W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] tb_bitrev(input logic [7:0] v);
      logic [7:0] r;
      for (int b = 0; b < 8; b++) r[b] = v[7 - b];
      return r;
   endfunction

   // ------------------------------------------------------------------------
   // Output monitor, sampled on the falling edge
   // ------------------------------------------------------------------------
   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1) begin
         if (stall_q) begin
            tests++;
            if (out_valid !== 1'b1 || out_data !== held_data) begin
               fails++;
               $display("FAIL stall_hold: got valid=%b data=%h, required valid=1 data=%h",
                        out_valid, out_data, held_data);
            end
         end
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            xfer_cnt++;
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_output: got data=%h last=%b, required no transfer",
                        out_data, out_last);
            end else begin
               e = exp_q.pop_front();
               if (out_data !== e.data || out_last !== e.last) begin
                  fails++;
                  $display("FAIL output_data: got data=%h last=%b, required data=%h last=%b",
                           out_data, out_last, e.data, e.last);
               end
            end
         end
         stall_q   = (out_valid === 1'b1 && out_ready === 1'b0);
         held_data = out_data;
      end else begin
         stall_q = 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------------
   task automatic push_frame(input int base, input bit hot0);
      exp_t e;
      for (int k = 0; k < N; k++) begin
         e.data = (hot0 && k == 0) ? 23'h7FFFFF : W'(base + int'(tb_bitrev(8'(k))));
         e.last = (k == N - 1);
         exp_q.push_back(e);
      end
   endtask

   // Leaves in_valid high after the last coefficient so frames can abut.
   task automatic feed_frame(input int base, input bit hot0);
      for (int i = 0; i < N; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         in_data  = (hot0 && i == 0) ? 23'h7FFFFF : W'(base + i);
      end
   endtask

   task automatic go_idle();
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = '0;
   endtask

   task automatic drain(input bit toggle, input int budget);
      int n;
      n = 0;
      out_ready = 1'b1;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clk); #1;
         out_ready = toggle ? ~out_ready : 1'b1;
         n++;
      end
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain_timeout: got %0d outputs pending, required 0", exp_q.size());
         exp_q.delete();
      end
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b0) begin
         fails++;
         $display("FAIL idle_after_drain: got out_valid=%b, required 0", out_valid);
      end
   endtask

   task automatic check_xfers(input string name, input int required);
      tests++;
      if (xfer_cnt !== required) begin
         fails++;
         $display("FAIL %s_count: got %0d transfers, required %0d", name, xfer_cnt, required);
      end
   endtask

   task automatic apply_reset();
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      exp_q.delete();
      xfer_cnt = 0;
   endtask

   // ------------------------------------------------------------------------
   // Scenarios
   // ------------------------------------------------------------------------
   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      tests += 3;
      if (out_valid !== 1'b0) begin
         fails++; $display("FAIL reset_valid: got %b, required 0", out_valid);
      end
      if (out_last !== 1'b0) begin
         fails++; $display("FAIL reset_last: got %b, required 0", out_last);
      end
      if (overflow !== 1'b0) begin
         fails++; $display("FAIL reset_overflow: got %b, required 0", overflow);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      xfer_cnt = 0;
   endtask

   task automatic test_single_frame();
      apply_reset();
      out_ready = 1'b1;
      push_frame(0, 1'b0);
      feed_frame(0, 1'b0);
      tests++;
      if (out_valid !== 1'b0) begin
         fails++; $display("FAIL early_valid: got out_valid=%b, required 0", out_valid);
      end
      go_idle();
      tests++;
      if (out_valid !== 1'b1) begin
         fails++; $display("FAIL latency_valid: got out_valid=%b, required 1", out_valid);
      end
      drain(1'b0, 2 * N);
      check_xfers("single", N);
   endtask

   task automatic test_backpressure();
      apply_reset();
      push_frame(0, 1'b0);
      feed_frame(0, 1'b0);
      go_idle();
      drain(1'b1, 4 * N);
      check_xfers("backpressure", N);
   endtask

   task automatic test_back_to_back();
      apply_reset();
      out_ready = 1'b1;
      for (int f = 0; f < 8; f++) begin
         push_frame(256 * f, 1'b0);
         feed_frame(256 * f, 1'b0);
      end
      go_idle();
      drain(1'b0, 4 * N);
      check_xfers("back_to_back", 8 * N);
      tests++;
      if (overflow !== 1'b0) begin
         fails++; $display("FAIL b2b_overflow: got %b, required 0", overflow);
      end
   endtask

   task automatic test_overflow();
      apply_reset();
      out_ready = 1'b0;
      push_frame(0, 1'b0);
      feed_frame(0, 1'b0);
      push_frame(256, 1'b0);
      feed_frame(256, 1'b0);
      for (int i = 0; i < N; i++) begin
         @(posedge clk); #1;
         if (i == 0) begin
            tests++;
            if (overflow !== 1'b0) begin
               fails++; $display("FAIL overflow_early: got %b, required 0", overflow);
            end
         end
         if (i == 1) begin
            tests++;
            if (overflow !== 1'b1) begin
               fails++; $display("FAIL overflow_rise: got %b, required 1", overflow);
            end
         end
         in_valid = 1'b1;
         in_data  = W'(512 + i);
      end
      go_idle();
      drain(1'b0, 4 * N);
      check_xfers("overflow", 2 * N);
      tests++;
      if (overflow !== 1'b1) begin
         fails++; $display("FAIL overflow_sticky: got %b, required 1", overflow);
      end
   endtask

   task automatic test_freeing_cycle();
      apply_reset();
      out_ready = 1'b0;
      push_frame(0, 1'b0);
      feed_frame(0, 1'b0);
      push_frame(256, 1'b0);
      feed_frame(256, 1'b0);
      go_idle();
      // Both banks are now full. Release the consumer, then line up frame 2's
      // first coefficient with the last read of bank 0.
      out_ready = 1'b1;
      repeat (N - 2) @(posedge clk);
      push_frame(0, 1'b1);
      for (int i = 0; i < N; i++) begin
         @(posedge clk); #1;
         if (i == 0) begin
            tests++;
            if (out_last !== 1'b1) begin
               fails++; $display("FAIL free_align: got out_last=%b, required 1", out_last);
            end
         end
         if (i == 1) begin
            tests++;
            if (overflow !== 1'b0) begin
               fails++; $display("FAIL free_overflow: got %b, required 0", overflow);
            end
         end
         in_valid = 1'b1;
         in_data  = (i == 0) ? 23'h7FFFFF : W'(i);
      end
      go_idle();
      drain(1'b0, 4 * N);
      check_xfers("freeing", 3 * N);
      tests++;
      if (overflow !== 1'b0) begin
         fails++; $display("FAIL free_overflow_end: got %b, required 0", overflow);
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      out_ready = 1'b0;
      feed_frame(4096, 1'b0);
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         in_data  = W'(8192 + i);
      end
      #3 rst_n = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      tests++;
      if (out_valid !== 1'b0) begin
         fails++; $display("FAIL mid_reset_async: got out_valid=%b, required 0", out_valid);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         tests++;
         if (out_valid !== 1'b0) begin
            fails++; $display("FAIL mid_reset_hold: got out_valid=%b, required 0", out_valid);
         end
      end
      @(posedge clk); #1 rst_n = 1'b1;
      xfer_cnt = 0;
      push_frame(1024, 1'b0);
      feed_frame(1024, 1'b0);
      go_idle();
      drain(1'b0, 2 * N);
      check_xfers("reset_mid", N);
   endtask

   initial begin
      tests    = 0;
      fails    = 0;
      xfer_cnt = 0;
      stall_q  = 1'b0;
      test_reset();
      test_single_frame();
      test_backpressure();
      test_back_to_back();
      test_overflow();
      test_freeing_cycle();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ntt_bitrev_buffer.md
# ntt_bitrev_buffer

Ping-pong reorder buffer placed directly downstream of the NTT core. It captures the core's 256-coefficient output frames, which the core streams in bit-reversed index order with no backpressure. It then re-emits each frame in natural index order over a valid/ready interface to the next consumer (pointwise multiplier or host read-out). Two 256×23-bit banks let one frame be written while the previous frame drains.

## Interface
- `N`, 256: coefficients per frame; power of two.
- `LOGN`, 8: log2(N); width of index counters.
- `W`, 23: coefficient width (Dilithium q = 8380417 fits).

- `clk`  in  1: single clock; all state updates on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: coefficient present on `in_data`; driven from NTT `output_valid`; no ready is returned.
- `in_data`  in  W: coefficient; driven from NTT `output_data`.
- `out_valid`  out  1: `out_data` holds a valid natural-order coefficient.
- `out_ready`  in  1: consumer accepts; a transfer occurs on a cycle with `out_valid & out_ready`.
- `out_data`  out  W: coefficient at natural index `rd_cnt` of the draining frame.
- `out_last`  out  1: high with `out_valid` when `rd_cnt == N-1`.
- `overflow`  out  1: sticky; set when an input coefficient is dropped.

## Operation
- Storage: `mem[2][N]` of W bits, flop/register-file based, with combinational read.
- Bank state, per bank: EMPTY → FILLING → FULL.
  - EMPTY → FILLING on the first accepted write.
  - FILLING → FULL on the write with `wr_cnt == N-1`.
  - FULL → EMPTY on the transfer with `rd_cnt == N-1`.
- Write side: pointer `wr_bank` and counter `wr_cnt[LOGN-1:0]`.
  - A write is accepted when `in_valid` is high and `bank[wr_bank]` is EMPTY or FILLING, or is FULL and being freed by the last read transfer in this same cycle.
  - On accept: `mem[wr_bank][bitrev(wr_cnt)] <= in_data`, then `wr_cnt++`.
  - When `wr_cnt == N-1`, `wr_cnt` wraps to 0 and `wr_bank` toggles.
  - `bitrev` reverses the LOGN bits, e.g. 1 → 128 and 3 → 192.
- Drop: `in_valid` arriving when no write can be accepted is discarded. `overflow` is set to 1, `wr_cnt` and `wr_bank` are unchanged, and `overflow` stays high until reset.
- Read side: pointer `rd_bank` and counter `rd_cnt`.
  - `out_valid = (bank[rd_bank] == FULL)`.
  - `out_data = mem[rd_bank][rd_cnt]`.
  - On each transfer `rd_cnt++`. On the transfer with `rd_cnt == N-1`, `rd_cnt` wraps to 0, the bank is freed, and `rd_bank` toggles.
- Frames leave in arrival order. Draining never starts on a partially filled bank.
- Reset (asynchronous, any time, including mid-frame):
  - Both banks EMPTY; `wr_bank = rd_bank = 0`; `wr_cnt = rd_cnt = 0`; `overflow = 0`.
  - `out_valid = 0`, `out_last = 0`, `out_data = mem[0][0]` (contents are don't-care; memory is not cleared).
  - A partial frame in progress is discarded.

## Timing
- Latency from frame complete to output: the edge that writes index N-1 makes the bank FULL, and `out_valid` is high in the next cycle.
- Full-rate streaming: with `out_ready` held high, a frame drains in N cycles. Back-to-back input frames at one coefficient per cycle are sustained without any drop.
- Simultaneous write and read: allowed every cycle. They target different banks, except on a freeing cycle, where the write goes to `bitrev(0) = 0` of the bank just released and that bank re-enters FILLING.
- `out_data` and `out_valid` must remain stable while `out_valid & ~out_ready`.
- No combinational path from `in_*` to `out_*`. `out_ready` only affects `out_*` through registered state.

## Test plan
- Single frame: feed `in_data = i` for i = 0..255 on consecutive cycles, with `out_ready = 1`.
  - `out_valid` rises one cycle after the last input.
  - Outputs are `bitrev(i)` in order: 0, 128, 64, 192, …, 255.
  - `out_last` is high only on the 256th output.
- Backpressure: same frame, with `out_ready` toggling 1,0,1,0.
  - Exactly 256 transfers, in identical order.
  - `out_data` is held during stalls.
- Back-to-back frames: 8 frames with `in_data = 256*f + i`, continuous input, `out_ready = 1`.
  - 2048 outputs, in correct order per frame.
  - `overflow` stays 0.
- Overflow: `out_ready = 0`, feed 3 full frames.
  - Frames 0 and 1 are stored, and `overflow` rises on the first coefficient of frame 2.
  - Then set `out_ready = 1`: frames 0 and 1 drain intact, and `overflow` remains 1.
- Freeing-cycle concurrency: both banks FULL, and frame 2's first coefficient (value 0x7FFFFF) arrives on the same cycle as the last read of bank 0.
  - The write is accepted and `overflow` stays 0.
  - Frame 2 later outputs 0x7FFFFF at index 0.
- Reset mid-operation: assert `rst_n = 0` after 100 inputs of a frame, release it, then feed a fresh frame.
  - `out_valid` is 0 throughout reset.
  - Only the fresh frame is output, in correct order.
